// File: rtl/serial_cla_subtractor.sv
// Serial subtractor: a - b - bin, one 4-bit carry-lookahead nibble per cycle, LSB first.
// Latency: done pulses NIBBLES cycles after the accepting edge; ready again one cycle later.
// Backpressure: start is only accepted while ready=1; it is ignored in RUN and DONE.
module serial_cla_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   bout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sh_q, sh_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            c_q, c_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Current nibble operands and carry-lookahead result
    logic [3:0]      nib_x, nib_y, nib_g, nib_p, nib_c, nib_sum;
    logic            nib_co;
    logic [W-1:0]    sh_nx;

    // 4-bit carry-lookahead adder on a[k] + ~b[k] + carry; all carries flattened from g/p
    always_comb begin
        nib_x = a_q[{idx_q, 2'b00} +: 4];
        nib_y = ~b_q[{idx_q, 2'b00} +: 4];
        nib_g = nib_x & nib_y;
        nib_p = nib_x ^ nib_y;
        nib_c[0] = c_q;
        nib_c[1] = nib_g[0] | (nib_p[0] & c_q);
        nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & c_q);
        nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & c_q);
        nib_co   = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & c_q);
        nib_sum  = nib_p ^ nib_c;
    end

    // Shadow result with the current nibble merged in
    always_comb begin
        sh_nx = sh_q;
        sh_nx[{idx_q, 2'b00} +: 4] = nib_sum;
    end

    // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        c_d     = c_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    c_d     = ~bin;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                sh_d = sh_nx;
                c_d  = nib_co;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    diff_d  = sh_nx;
                    bout_d  = ~nib_co;
                    ovf_d   = (a_q[W-1] != b_q[W-1]) && (sh_nx[W-1] != a_q[W-1]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation and clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;

endmodule
